// File: rtl/prog_scheduler.sv
// prog_scheduler: steps a processor through programs 1..NUM_PROGS using LOAD/RUN/DONE phases.
// Define PROG_TIMEOUT_EN to build in the RUN-state watchdog. Without it, timeout_err is tied to 0.
module prog_scheduler #(
  parameter int ADDR_W         = 8,
  parameter int NUM_PROGS      = 3,
  parameter int PROG1_ADDR     = 0,
  parameter int PROG2_ADDR     = 0,
  parameter int PROG3_ADDR     = 0,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              CLK,
  input  logic              init_n,
  input  logic              start,
  input  logic              done,
  output logic [1:0]        prog_state,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_start_addr,
  output logic              proc_hold,
  output logic              prog_done,
  output logic [15:0]       cycles,
  output logic              busy,
  output logic              all_done,
  output logic              timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DONE, S_FINISH} state_t;

  localparam logic [15:0] TO_LIM    = 16'(TIMEOUT_CYCLES);
  localparam logic [1:0]  LAST_PROG = 2'(NUM_PROGS);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic        w_timeout;

  function automatic logic [ADDR_W-1:0] prog_addr(input logic [1:0] n);
    case (n)
      2'd2:    prog_addr = ADDR_W'(PROG2_ADDR);
      2'd3:    prog_addr = ADDR_W'(PROG3_ADDR);
      default: prog_addr = ADDR_W'(PROG1_ADDR);
    endcase
  endfunction

  // Count of RUN cycles including the current one, saturating.
  assign w_cnt_next = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

`ifdef PROG_TIMEOUT_EN
  assign w_timeout = (w_cnt_next >= TO_LIM);
`else
  logic w_unused_to;
  assign w_unused_to = ^TO_LIM;
  assign w_timeout   = 1'b0;
`endif

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      prog_state    <= '0;
      cycles        <= '0;
      timeout_err   <= 1'b0;
      pc_load       <= 1'b0;
      pc_start_addr <= '0;
      prog_done     <= 1'b0;
      busy          <= 1'b0;
      all_done      <= 1'b0;
      proc_hold     <= 1'b1;
    end else begin
      pc_load       <= 1'b0;
      pc_start_addr <= '0;
      prog_done     <= 1'b0;
      case (r_state)
        S_IDLE, S_FINISH: begin
          if (start) begin
            r_state       <= S_LOAD;
            prog_state    <= 2'd1;
            pc_load       <= 1'b1;
            pc_start_addr <= prog_addr(2'd1);
            busy          <= 1'b1;
            all_done      <= 1'b0;
            timeout_err   <= 1'b0;
            proc_hold     <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state   <= S_RUN;
          r_cnt     <= '0;
          proc_hold <= 1'b0;
        end
        S_RUN: begin
          r_cnt <= w_cnt_next;
          if (done || w_timeout) begin
            r_state   <= S_DONE;
            cycles    <= w_cnt_next;
            prog_done <= 1'b1;
            proc_hold <= 1'b1;
            // A real done in the same cycle as the limit wins over the watchdog.
            if (!done) timeout_err <= 1'b1;
          end
        end
        S_DONE: begin
          if (prog_state < LAST_PROG) begin
            r_state       <= S_LOAD;
            prog_state    <= prog_state + 2'd1;
            pc_load       <= 1'b1;
            pc_start_addr <= prog_addr(prog_state + 2'd1);
          end else begin
            r_state  <= S_FINISH;
            busy     <= 1'b0;
            all_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_scheduler.sv
// Bench for prog_scheduler: random program lengths and start noise, checked against run-level expectations.
// Watchdog expectations follow whether PROG_TIMEOUT_EN is defined for the build.
module tb_prog_scheduler;
  localparam int TO = 10;
`ifdef PROG_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        init_n, start, done, start1, done1;
  logic [1:0]  prog_state, prog_state1;
  logic        pc_load, pc_load1, proc_hold, proc_hold1, prog_done, prog_done1;
  logic [7:0]  pc_start_addr, pc_start_addr1;
  logic [15:0] cycles, cycles1;
  logic        busy, busy1, all_done, all_done1, timeout_err, timeout_err1;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_err = 1'b0;
  logic saw_p2  = 1'b0;

  prog_scheduler #(.ADDR_W(8), .NUM_PROGS(3), .PROG1_ADDR(8'h00), .PROG2_ADDR(8'h20),
                   .PROG3_ADDR(8'h40), .TIMEOUT_CYCLES(TO)) u_dut (
    .CLK(clk), .init_n(init_n), .start(start), .done(done),
    .prog_state(prog_state), .pc_load(pc_load), .pc_start_addr(pc_start_addr),
    .proc_hold(proc_hold), .prog_done(prog_done), .cycles(cycles), .busy(busy),
    .all_done(all_done), .timeout_err(timeout_err));

  prog_scheduler #(.ADDR_W(8), .NUM_PROGS(1), .PROG1_ADDR(8'h11), .PROG2_ADDR(8'h55),
                   .PROG3_ADDR(8'h66), .TIMEOUT_CYCLES(TO)) u_one (
    .CLK(clk), .init_n(init_n), .start(start1), .done(done1),
    .prog_state(prog_state1), .pc_load(pc_load1), .pc_start_addr(pc_start_addr1),
    .proc_hold(proc_hold1), .prog_done(prog_done1), .cycles(cycles1), .busy(busy1),
    .all_done(all_done1), .timeout_err(timeout_err1));

  always @(negedge clk) if (pc_start_addr1 == 8'h55) saw_p2 = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_addr(input int n);
    case (n)
      2:       return 8'h20;
      3:       return 8'h40;
      default: return 8'h00;
    endcase
  endfunction

  // Entered at the negedge just after the edge that moved into LOAD for program n.
  task automatic run_prog(input int n, input int len, input bit rnd_start, input int np);
    int eff;
    eff = (TO_EN && len > TO) ? TO : len;
    check("load_pulse", pc_load, 1);
    check("load_addr", pc_start_addr, exp_addr(n));
    check("load_state", prog_state, n);
    check("load_hold", proc_hold, 1);
    check("load_busy", busy, 1);
    done = 1'($urandom_range(0, 1));
    if (rnd_start) start = 1'($urandom_range(0, 1));
    for (int k = 1; k <= eff; k++) begin
      tick();
      check("run_hold", proc_hold, 0);
      check("run_noload", pc_load, 0);
      check("run_addr0", pc_start_addr, 0);
      check("run_state", prog_state, n);
      done = (k == len);
      if (rnd_start) start = 1'($urandom_range(0, 1));
    end
    tick();
    if (TO_EN && len > TO) exp_err = 1'b1;
    check("prog_done", prog_done, 1);
    check("cycles", cycles, eff);
    check("done_hold", proc_hold, 1);
    check("timeout_err", timeout_err, exp_err);
    check("done_state", prog_state, n);
    done = 1'($urandom_range(0, 1));
    tick();
    done = 1'b0;
    check("prog_done_pulse", prog_done, 0);
    if (n >= np) begin
      start = 1'b0;
      check("all_done", all_done, 1);
      check("finish_busy", busy, 0);
      check("finish_state", prog_state, n);
      check("finish_hold", proc_hold, 1);
    end
  endtask

  task automatic run_seq(input int l1, input int l2, input int l3, input bit rnd_start);
    start = 1'b1;
    tick();
    exp_err = 1'b0;
    if (!rnd_start) start = 1'b0;
    check("start_clr_all_done", all_done, 0);
    check("start_clr_err", timeout_err, 0);
    run_prog(1, l1, rnd_start, 3);
    run_prog(2, l2, rnd_start, 3);
    run_prog(3, l3, rnd_start, 3);
  endtask

  initial begin
    init_n = 1'b1; start = 1'b0; done = 1'b0; start1 = 1'b0; done1 = 1'b0;
    #1 init_n = 1'b0;
    #3;
    check("rst_state", prog_state, 0);
    check("rst_hold", proc_hold, 1);
    check("rst_busy", busy, 0);
    check("rst_load", pc_load, 0);
    @(negedge clk);
    init_n = 1'b1;
    repeat (3) tick();
    check("idle_no_autostart", prog_state, 0);
    check("idle_no_load", pc_load, 0);

    run_seq(5, 7, 3, 1'b0);
    repeat (2) tick();
    check("finish_hold_state", prog_state, 3);
    check("finish_hold_all_done", all_done, 1);

    start = 1'b1;
    run_seq(4, 6, 2, 1'b0);
    start = 1'b1;
    tick();
    exp_err = 1'b0;
    check("start_held_clear", all_done, 0);
    run_prog(1, 3, 1'b0, 3);
    run_prog(2, 5, 1'b0, 3);
    run_prog(3, 2, 1'b0, 3);

    run_seq(10, 15, 4, 1'b0);
    for (int i = 0; i < 5; i++)
      run_seq($urandom_range(1, 20), $urandom_range(1, 20), $urandom_range(1, 20), 1'b1);

    start = 1'b1;
    tick();
    start = 1'b0;
    run_prog(1, 2, 1'b0, 3);
    check("p2_load", pc_start_addr, 8'h20);
    repeat (3) tick();
    check("p2_in_run", proc_hold, 0);
    #2 init_n = 1'b0;
    #1;
    check("arst_state", prog_state, 0);
    check("arst_hold", proc_hold, 1);
    check("arst_busy", busy, 0);
    check("arst_cycles", cycles, 0);
    check("arst_addr", pc_start_addr, 0);
    check("arst_flags", {pc_load, prog_done, all_done, timeout_err}, 0);
    @(negedge clk);
    init_n = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", prog_state, 0);
    check("post_rst_noload", pc_load, 0);
    run_seq(3, 3, 3, 1'b0);

    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("one_load", pc_load1, 1);
    check("one_addr", pc_start_addr1, 8'h11);
    for (int k = 1; k <= 4; k++) begin
      tick();
      done1 = (k == 4);
    end
    tick();
    done1 = 1'b0;
    check("one_prog_done", prog_done1, 1);
    check("one_cycles", cycles1, 4);
    tick();
    check("one_all_done", all_done1, 1);
    check("one_state", prog_state1, 1);
    check("one_no_p2", saw_p2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/prog_scheduler.md
PROG_SCHEDULER -- requirements
Module: prog_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 8, program-counter width.
- NUM_PROGS, 3, programs per run, range 1..3.
- PROG1_ADDR, 0, start address of program 1.
- PROG2_ADDR, 0, start address of program 2.
- PROG3_ADDR, 0, start address of program 3.
- TIMEOUT_CYCLES, 1023, watchdog limit in RUN.
REQ-002 Ports (name, direction, width, meaning), clock and reset first; one clock; reset is asynchronous and active-low:
- CLK, in, 1, rising-edge clock.
- init_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin a run of programs 1..NUM_PROGS.
- done, in, 1, processor reports the current program finished.
- prog_state, out, 2, current program number (0 = none, 1..3).
- pc_load, out, 1, one-cycle load strobe for the program counter.
- pc_start_addr, out, ADDR_W, address loaded into the PC.
- proc_hold, out, 1, holds the processor stalled.
- prog_done, out, 1, one-cycle pulse when a program completes.
- cycles, out, 16, RUN cycle count of the last completed program.
- busy, out, 1, high in every state except IDLE and FINISH.
- all_done, out, 1, high after the last program completes.
- timeout_err, out, 1, sticky watchdog error flag.

Function
REQ-003 States SHALL be IDLE, LOAD, RUN, DONE, FINISH; next state is evaluated on the rising edge of CLK.
REQ-004 IDLE SHALL move to LOAD when start=1, setting prog_state=1.
REQ-005 LOAD SHALL last exactly 1 cycle with pc_load=1, proc_hold=1, and pc_start_addr=PROGn_ADDR for n=prog_state, then move to RUN.
REQ-006 RUN SHALL hold proc_hold=0 and increment an internal counter each cycle; the counter SHALL saturate at 16'hFFFF and clear on entry to RUN.
REQ-007 RUN SHALL move to DONE on the first cycle with done=1; the counter value including that cycle SHALL be copied to cycles.
REQ-008 DONE SHALL last 1 cycle with prog_done=1 and proc_hold=1.
REQ-009 From DONE, if prog_state<NUM_PROGS the block SHALL increment prog_state and go to LOAD; otherwise it SHALL go to FINISH.
REQ-010 FINISH SHALL assert all_done=1 and proc_hold=1 while keeping prog_state; start=1 SHALL clear all_done, set prog_state=1 and go to LOAD.
REQ-011 start SHALL be ignored in LOAD, RUN and DONE.
REQ-012 done SHALL be ignored outside RUN.
REQ-013 pc_start_addr SHALL be driven only in LOAD and be 0 otherwise.
REQ-014 proc_hold SHALL be 1 in every state except RUN.
REQ-015 Latency: start to pc_load SHALL be 1 cycle; done to prog_done SHALL be 1 cycle; prog_done to the next pc_load SHALL be 1 cycle.

Reset
REQ-016 init_n=0 SHALL asynchronously force state to IDLE, with immediate effect including mid-RUN, and reset outputs to:
- prog_state=0, cycles=0, timeout_err=0
- pc_load=0, pc_start_addr=0, prog_done=0, busy=0, all_done=0
- proc_hold=1
REQ-017 The internal counter SHALL reset to 0.
REQ-018 Release of init_n SHALL NOT by itself start a run; start is required.

Configuration
REQ-019 Macro PROG_TIMEOUT_EN SHALL compile the RUN-state watchdog in or out.
REQ-020 With PROG_TIMEOUT_EN defined:
- When the RUN counter reaches TIMEOUT_CYCLES with done=0, the block SHALL set timeout_err=1 and go to DONE as if done were seen.
- done and timeout in the same cycle SHALL count as done, with no error.
- timeout_err SHALL clear only on reset or on an accepted start.
REQ-021 Without PROG_TIMEOUT_EN, RUN SHALL wait for done indefinitely and timeout_err SHALL be tied to 0.

Verification
REQ-022 Normal run: NUM_PROGS=3, PROG1..3_ADDR=8'h00/8'h20/8'h40, done pulsed after 5, 7 and 3 RUN cycles -> pc_start_addr sequence 00/20/40, cycles 5/7/3, three prog_done pulses, then all_done=1 with prog_state=3.
REQ-023 start held high during RUN -> no reload, and prog_state is unchanged.
REQ-024 init_n pulled low mid-RUN of program 2 -> outputs reach reset values with no clock edge; after release, start restarts at prog_state=1.
REQ-025 PROG_TIMEOUT_EN with TIMEOUT_CYCLES=10 and done never asserted -> DONE entered on RUN cycle 10, timeout_err=1, cycles=10, and the next program loads; done asserted on cycle 10 -> timeout_err stays 0.
REQ-026 NUM_PROGS=1 -> after one program, FINISH is reached and PROG2_ADDR is never driven.
REQ-027 start issued in FINISH -> all_done clears and pc_load rises 1 cycle later with PROG1_ADDR.
